// File: rtl/pattern_detect_pkg.sv
// pattern_detect_pkg: shared ASCII constants, case folding helper and default pattern
package pattern_detect_pkg;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7a;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
  localparam logic [39:0] PAT_HELLO = "HELLO";
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z) ? c - ASCII_CASE_OFFSET : c;
  endfunction
endpackage

// File: rtl/pattern_window.sv
// pattern_window: sliding symbol window with fill counter and full-window compare
module pattern_window #(
  parameter int DATA_W = 8,
  parameter int PAT_LEN = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      valid,
  input  logic                      restart,
  input  logic [PAT_LEN*DATA_W-1:0] pat,
  output logic                      hit
);
  localparam int FW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN*DATA_W-1:0] win, nxt;
  logic [FW-1:0] fill;
  // oldest symbol drifts toward the MSBs, matching the pattern layout
  assign nxt = {win[(PAT_LEN-1)*DATA_W-1:0], din};
  assign hit = valid && fill >= FW'(PAT_LEN - 1) && nxt == pat;
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
      fill <= '0;
    end else if (valid) begin
      win <= nxt;
      fill <= restart ? '0 : (fill == FW'(PAT_LEN)) ? fill : fill + 1'b1;
    end
  end
endmodule

// File: rtl/pattern_detect.sv
// pattern_detect: streaming pattern detector with match pulse, toggling led and saturating count
// optional PATTERN_DETECT_CASE_FOLD_EN folds lowercase ASCII before shift and compare
module pattern_detect
  import pattern_detect_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_LEN = 5,
  parameter logic [PAT_LEN*DATA_W-1:0] PATTERN = PAT_HELLO,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  input  logic              clr_cnt,
  output logic              match,
  output logic              led,
  output logic [CNT_W-1:0]  match_cnt
);
  logic [DATA_W-1:0] sym;
  logic [PAT_LEN*DATA_W-1:0] pat;
  logic hit, restart;
`ifdef PATTERN_DETECT_CASE_FOLD_EN
  if (DATA_W == 8) begin : g_fold
    assign sym = fold_case(data);
    for (genvar i = 0; i < PAT_LEN; i++) begin : g_p
      assign pat[i*8 +: 8] = fold_case(PATTERN[i*8 +: 8]);
    end
  end else begin : g_nofold
    assign sym = data;
    assign pat = PATTERN;
  end
`else
  assign sym = data;
  assign pat = PATTERN;
`endif
  assign restart = (OVERLAP == 0) && hit;
  pattern_window #(.DATA_W(DATA_W), .PAT_LEN(PAT_LEN)) u_win (
    .clk(clk_50mhz),
    .rst(rst),
    .din(sym),
    .valid(data_valid),
    .restart(restart),
    .pat(pat),
    .hit(hit)
  );
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      match <= 1'b0;
      led <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;
      led <= led ^ hit;
      match_cnt <= clr_cnt ? '0 : (hit && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
    end
  end
endmodule
